// File: rtl/adc_capture_buffer.sv
// rtl/adc_capture_buffer.sv - multi-channel ADC capture into a circular RAM with decimation, pre-trigger and triggering
//
// Captures NCH = 2**CH_BITS signed channels into a DEPTH = 2**ADDR_BITS deep
// circular buffer, with a programmable pre-trigger depth. Bus reads are
// trigger-relative: logical index 0 is the oldest pre-trigger sample.
//
// Optional build macro: ADC_CAPTURE_AVG_EN
//   defined   - each decimation group is summed and arithmetically shifted (averaged)
//   undefined - plain subsampling: the last sample of each group is stored
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   data_i, valid_i  packed samples (channel c at [c*DW +: DW]) and qualifier
//   arm_i, abort_i   start/restart a capture, or cancel it (abort wins)
//   sw_trig_i        software trigger pulse
//   lvl_trig_en_i, trig_ch_i, trig_level_i   rising-edge level trigger setup
//   pretrig_i        samples kept before the trigger
//   decim_log2_i     decimation exponent k (ratio 2^k)
//   rd_en_i, rd_addr_i, rd_data_o, rd_ack_o  bus read port, {index, channel} addressing
//   state_o, done_o, trig_addr_o             status
module adc_capture_buffer #(
    parameter int CH_BITS   = 1,
    parameter int DW        = 16,
    parameter int ADDR_BITS = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [(2**CH_BITS)*DW-1:0]    data_i,
    input  logic                          valid_i,
    input  logic                          arm_i,
    input  logic                          abort_i,
    input  logic                          sw_trig_i,
    input  logic                          lvl_trig_en_i,
    input  logic [CH_BITS-1:0]            trig_ch_i,
    input  logic [DW-1:0]                 trig_level_i,
    input  logic [ADDR_BITS-1:0]          pretrig_i,
    input  logic [3:0]                    decim_log2_i,
    input  logic                          rd_en_i,
    input  logic [ADDR_BITS+CH_BITS-1:0]  rd_addr_i,
    output logic [31:0]                   rd_data_o,
    output logic                          rd_ack_o,
    output logic [2:0]                    state_o,
    output logic                          done_o,
    output logic [ADDR_BITS-1:0]          trig_addr_o
);
    localparam int NCH = 2**CH_BITS;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_ARMED = 3'd2,
        S_POST  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 state, state_nxt;
    logic [14:0]            dec_cnt, dec_mask;
    logic                   s, wr_en, trig_fire, lvl_fire, sw_pend, prev_valid;
    logic [ADDR_BITS-1:0]   wptr, p_reg, pre_cnt, rem_cnt, rem_init, start_addr, rd_phys;
    logic signed [DW-1:0]   prev_smp, cur_smp, rd_smp;
    logic [NCH*DW-1:0]      store_word, rd_word;
    logic [CH_BITS-1:0]     rd_ch;
    logic [NCH*DW-1:0]      mem [2**ADDR_BITS];

    // Decimator: strobe s on the last valid beat of each 2^k group. A beat
    // coinciding with arm_i is dropped so the new capture starts group-aligned.
    assign dec_mask = 15'((16'd1 << decim_log2_i) - 16'd1);
    assign s        = valid_i && (dec_cnt == dec_mask) && !arm_i;

`ifdef ADC_CAPTURE_AVG_EN
    localparam int AW = DW + 15;
    logic signed [AW-1:0] acc [NCH];
    logic signed [AW-1:0] acc_sum [NCH];

    always_comb begin
        store_word = '0;
        for (int c = 0; c < NCH; c++) begin
            // First beat of a group reloads instead of accumulating.
            acc_sum[c] = ((dec_cnt == 15'd0) ? {AW{1'b0}} : acc[c])
                       + AW'($signed(data_i[c*DW +: DW]));
            store_word[c*DW +: DW] = DW'(acc_sum[c] >>> decim_log2_i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) acc[c] <= '0;
        end else if (valid_i) begin
            for (int c = 0; c < NCH; c++) acc[c] <= acc_sum[c];
        end
    end
`else
    assign store_word = data_i;
`endif

    assign cur_smp   = $signed(store_word[trig_ch_i*DW +: DW]);
    assign lvl_fire  = lvl_trig_en_i && prev_valid
                    && (prev_smp < $signed(trig_level_i)) && (cur_smp >= $signed(trig_level_i));
    assign trig_fire = (state == S_ARMED) && s && (sw_pend || sw_trig_i || lvl_fire);
    assign wr_en     = s && !abort_i
                    && ((state == S_PRE) || (state == S_ARMED) || (state == S_POST));
    // pretrig_i cannot exceed DEPTH-1 at this width, so it is used unclamped.
    assign rem_init  = {ADDR_BITS{1'b1}} - p_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort_i) begin
            state_nxt = S_IDLE;
        end else if (arm_i) begin
            state_nxt = (pretrig_i == '0) ? S_ARMED : S_PRE;
        end else if (s) begin
            case (state)
                S_PRE:   if (pre_cnt == p_reg - 1'b1) state_nxt = S_ARMED;
                S_ARMED: if (trig_fire) state_nxt = (rem_init == '0) ? S_DONE : S_POST;
                S_POST:  if (rem_cnt == 1) state_nxt = S_DONE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_cnt <= '0;
        end else if (arm_i) begin
            dec_cnt <= '0;
        end else if (valid_i) begin
            dec_cnt <= (dec_cnt == dec_mask) ? 15'd0 : dec_cnt + 15'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr        <= '0;
            p_reg       <= '0;
            pre_cnt     <= '0;
            rem_cnt     <= '0;
            trig_addr_o <= '0;
            sw_pend     <= 1'b0;
            prev_valid  <= 1'b0;
            prev_smp    <= '0;
        end else if (abort_i) begin
            sw_pend <= 1'b0;
        end else if (arm_i) begin
            // A software trigger coinciding with arm is intentionally lost.
            wptr       <= '0;
            p_reg      <= pretrig_i;
            pre_cnt    <= '0;
            sw_pend    <= 1'b0;
            prev_valid <= 1'b0;
        end else begin
            if (wr_en) begin
                wptr       <= wptr + 1'b1;
                prev_smp   <= cur_smp;
                prev_valid <= 1'b1;
            end
            if ((state == S_PRE) && s) pre_cnt <= pre_cnt + 1'b1;
            if (trig_fire) begin
                trig_addr_o <= wptr;
                rem_cnt     <= rem_init;
            end else if ((state == S_POST) && s) begin
                rem_cnt <= rem_cnt - 1'b1;
            end
            // Software trigger is remembered only while armed, until the next stored sample.
            if (state == S_ARMED) sw_pend <= s ? 1'b0 : (sw_pend || sw_trig_i);
            else                  sw_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr] <= store_word;
    end

    assign start_addr = trig_addr_o - p_reg;
    assign rd_phys    = start_addr + rd_addr_i[ADDR_BITS+CH_BITS-1:CH_BITS];
    assign rd_ch      = rd_addr_i[CH_BITS-1:0];
    assign rd_word    = mem[rd_phys];
    assign rd_smp     = $signed(rd_word[rd_ch*DW +: DW]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ack_o  <= 1'b0;
            rd_data_o <= '0;
        end else begin
            rd_ack_o <= rd_en_i;
            if (rd_en_i) rd_data_o <= 32'(rd_smp);
        end
    end

    assign state_o = state;
    assign done_o  = (state == S_DONE);
endmodule
